// File: rtl/seven_seg_scan_mux.sv
// Three-digit seven-segment scan multiplexer with tear-free frame-boundary updates and blank guard slots.
// Optional macro BRIGHTNESS_EN adds a bright[3:0] input and a 4-bit PWM gate on the digit enable.
module seven_seg_scan_mux #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] seg0_in,
  input  logic [6:0] seg1_in,
  input  logic [6:0] seg2_in,
`ifdef BRIGHTNESS_EN
  input  logic [3:0] bright,
`endif
  output logic [6:0] seg_out,
  output logic [2:0] dig_en,
  output logic       frame_done
);

  localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]    DIG_OFF   = DIG_ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_e;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            pending_q, pending_d;
  logic [2:0][6:0] sh_q, sh_d;
  logic [2:0][6:0] ac_q, ac_d;
  logic [6:0]      seg_q, seg_d;
  logic [2:0]      dig_q, dig_d;
  logic            frame_done_q, frame_done_d;

  phase_e          phase;
  logic            boundary;
  logic            digit_on;
  logic [2:0][6:0] in_pat;
  logic [6:0]      cur_pat;
  logic [6:0]      seg_raw;
  logic [2:0]      dig_raw;

`ifdef BRIGHTNESS_EN
  logic [3:0] pwm_q, pwm_d;
`endif

  assign in_pat = {seg2_in, seg1_in, seg0_in};

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    pending_d    = pending_q;
    sh_d         = sh_q;
    ac_d         = ac_q;
    boundary     = (cnt_q == CNT_LAST) && (idx_q == 2'd2);
    frame_done_d = boundary;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    // A strobe on the boundary itself goes straight to the active set and beats any older shadow.
    if (boundary) begin
      if (load) begin
        ac_d = in_pat;
      end else if (pending_q) begin
        ac_d = sh_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      sh_d      = in_pat;
      pending_d = 1'b1;
    end

    phase = (cnt_q < BLANK_END) ? PH_BLANK : PH_SHOW;

    case (idx_q)
      2'd0:    cur_pat = ac_q[0];
      2'd1:    cur_pat = ac_q[1];
      default: cur_pat = ac_q[2];
    endcase

`ifdef BRIGHTNESS_EN
    pwm_d    = pwm_q + 4'd1;
    digit_on = (phase == PH_SHOW) && ((bright == 4'hF) || (pwm_q < bright));
`else
    digit_on = (phase == PH_SHOW);
`endif

    seg_raw = (phase == PH_SHOW) ? cur_pat : 7'h00;
    dig_raw = digit_on ? (3'b001 << idx_q) : 3'b000;
    seg_d   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dig_d   = DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      pending_q    <= 1'b0;
      // NOTE: the pattern stores are reset too, so a stale pending load can never surface after reset.
      sh_q         <= '0;
      ac_q         <= '0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      sh_q         <= sh_d;
      ac_q         <= ac_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef BRIGHTNESS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`endif

  assign seg_out    = seg_q;
  assign dig_en     = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux with REFRESH_DIV=8, BLANK_CYCLES=2, active-low segments and digits.
// Frame positions count from the state right after reset or a frame boundary (cnt=j%8, idx=j/8).
module tb_seven_seg_scan_mux;

  localparam int RD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [6:0] seg0_in, seg1_in, seg2_in;
`ifdef BRIGHTNESS_EN
  logic [3:0] bright;
`endif
  logic [6:0] seg_out;
  logic [2:0] dig_en;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_mux #(
    .REFRESH_DIV   (RD),
    .BLANK_CYCLES  (BC),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .seg0_in   (seg0_in),
    .seg1_in   (seg1_in),
    .seg2_in   (seg2_in),
`ifdef BRIGHTNESS_EN
    .bright    (bright),
`endif
    .seg_out   (seg_out),
    .dig_en    (dig_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps positions first..last of a frame; e0..e2 are the expected bus values while each digit shows.
  task automatic run_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input int first, input int last, input int load_at,
                           input logic [6:0] l0, input logic [6:0] l1, input logic [6:0] l2);
    int         c;
    int         d;
    logic [2:0] ed;
    logic [6:0] es;
    for (int j = first; j <= last; j++) begin
      if (j == load_at) begin
        load    = 1'b1;
        seg0_in = l0;
        seg1_in = l1;
        seg2_in = l2;
      end
      tick();
      load = 1'b0;
      c = j % RD;
      d = j / RD;
      if (c < BC) begin
        ed = 3'b111;
        es = 7'h7F;
      end else begin
        ed = (d == 0) ? 3'b110 : (d == 1) ? 3'b101 : 3'b011;
        es = (d == 0) ? e0 : (d == 1) ? e1 : e2;
      end
      check($sformatf("%s_dig_p%0d", tag, j), {29'd0, dig_en}, {29'd0, ed});
      check($sformatf("%s_seg_p%0d", tag, j), {25'd0, seg_out}, {25'd0, es});
      check($sformatf("%s_fd_p%0d", tag, j), {31'd0, frame_done}, {31'd0, (j == 3 * RD - 1)});
    end
  endtask

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    seg0_in = 7'h00;
    seg1_in = 7'h00;
    seg2_in = 7'h00;
`ifdef BRIGHTNESS_EN
    bright  = 4'hF;
`endif
    tick();
    tick();
    check("rst_dig", {29'd0, dig_en}, 32'h7);
    check("rst_seg", {25'd0, seg_out}, 32'h7F);
    check("rst_fd", {31'd0, frame_done}, 32'h0);
    rst = 1'b0;

    // Blank patterns until the first boundary, which loads 3F/06/5B directly.
    run_frame("f1", 7'h7F, 7'h7F, 7'h7F, 0, 23, 23, 7'h3F, 7'h06, 7'h5B);
    // Mid-frame load of 06 on digit 0 must not disturb this frame.
    run_frame("f2", 7'h40, 7'h79, 7'h24, 0, 23, 5, 7'h06, 7'h06, 7'h5B);
    // Load A mid-frame, then B on the boundary: B must win.
    run_frame("f3a", 7'h79, 7'h79, 7'h24, 0, 22, 10, 7'h7F, 7'h7F, 7'h7F);
    run_frame("f3b", 7'h79, 7'h79, 7'h24, 23, 23, 23, 7'h01, 7'h02, 7'h04);
    run_frame("f4", 7'h7E, 7'h7D, 7'h7B, 0, 23, -1, 7'h00, 7'h00, 7'h00);
    // B still shown, so no stale pending shadow was applied; then queue C and reset during digit 1 SHOW.
    run_frame("f5", 7'h7E, 7'h7D, 7'h7B, 0, 11, 3, 7'h3F, 7'h3F, 7'h3F);
    rst = 1'b1;
    tick();
    check("mid_rst_dig", {29'd0, dig_en}, 32'h7);
    check("mid_rst_seg", {25'd0, seg_out}, 32'h7F);
    check("mid_rst_fd", {31'd0, frame_done}, 32'h0);
    rst = 1'b0;
    // Scan restarts at digit 0 with cleared patterns; C must never appear.
    run_frame("f6", 7'h7F, 7'h7F, 7'h7F, 0, 23, -1, 7'h00, 7'h00, 7'h00);
    run_frame("f7", 7'h7F, 7'h7F, 7'h7F, 0, 23, -1, 7'h00, 7'h00, 7'h00);

`ifdef BRIGHTNESS_EN
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    bright = 4'd4;
    // pwm restarts at 0 with the scan, so position p sees pwm = p % 16.
    for (int p = 0; p < 48; p++) begin
      logic [2:0] ed;
      tick();
      if ((p % RD) < BC || (p % 16) >= 4) ed = 3'b111;
      else ed = ((p / RD) % 3 == 0) ? 3'b110 : ((p / RD) % 3 == 1) ? 3'b101 : 3'b011;
      check($sformatf("br4_dig_p%0d", p), {29'd0, dig_en}, {29'd0, ed});
    end
    bright = 4'd0;
    for (int p = 0; p < 24; p++) begin
      tick();
      check($sformatf("br0_dig_p%0d", p), {29'd0, dig_en}, 32'h7);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
